// File: rtl/sound_pkg.sv
// Shared types, tone constants and jingle sheets for the sound sequencer.
package sound_pkg;

  localparam int unsigned N_REQ     = 4;
  localparam int unsigned ID_W      = 2;
  localparam int unsigned STEP_W    = 3;
  localparam int unsigned MAX_STEPS = 8;

  typedef logic [3:0] tone_t;

  localparam tone_t DO       = 4'h0;
  localparam tone_t DO_DIEZ  = 4'h1;
  localparam tone_t RE       = 4'h2;
  localparam tone_t RE_DIEZ  = 4'h3;
  localparam tone_t MI       = 4'h4;
  localparam tone_t FA       = 4'h5;
  localparam tone_t FA_DIEZ  = 4'h6;
  localparam tone_t SOL      = 4'h7;
  localparam tone_t SOL_DIEZ = 4'h8;
  localparam tone_t LA       = 4'h9;
  localparam tone_t LA_DIEZ  = 4'hA;
  localparam tone_t SI       = 4'hB;
  localparam tone_t REST     = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Jingle lengths in eighth-notes, indexed by request id.
  localparam logic [3:0] SHEET_LEN [N_REQ] = '{4'd2, 4'd4, 4'd3, 4'd2};

  // id0 cue strike, id1 collision, id2 pocket, id3 win; unused slots are rests.
  localparam tone_t SHEET [N_REQ][MAX_STEPS] = '{
    '{DO,      MI,      REST, REST, REST, REST, REST, REST},
    '{RE,      FA,      REST, SOL,  REST, REST, REST, REST},
    '{SOL,     LA,      SI,   REST, REST, REST, REST, REST},
    '{DO_DIEZ, RE_DIEZ, REST, REST, REST, REST, REST, REST}
  };

endpackage

// File: rtl/sound_sheet_rom.sv
// Combinational sheet lookup: {id, step} -> tone.
module sound_sheet_rom
  import sound_pkg::*;
(
  input  logic [ID_W-1:0]   id,
  input  logic [STEP_W-1:0] step,
  output tone_t             tone_c
);

  assign tone_c = SHEET[id][step];

endmodule

// File: rtl/sound_sequencer.sv
// Frame-paced jingle scheduler: latches requests, arbitrates by fixed
// priority and plays one eighth-note per FRAMES_PER_EIGHTH frames.
module sound_sequencer
  import sound_pkg::*;
#(
  parameter int unsigned FRAMES_PER_EIGHTH = 6,
  parameter int unsigned GAP_FRAMES        = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_of_frame,
  input  logic [N_REQ-1:0] req,
  input  logic             mute,
  output tone_t            tone_key,
  output logic             sound_enable,
  output logic             busy,
  output logic [ID_W-1:0]  active_id,
  output logic             done
);

  localparam int unsigned CNT_MAX = (FRAMES_PER_EIGHTH > GAP_FRAMES) ? FRAMES_PER_EIGHTH : GAP_FRAMES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] EIGHTH_LAST = CNT_W'(FRAMES_PER_EIGHTH - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_FRAMES - 1);

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   pending_q, pending_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               done_q, done_d;
  logic [N_REQ-1:0]   req_mask;
  logic [ID_W-1:0]    sel;
  logic               higher;
  logic [STEP_W-1:0]  last_step;
  tone_t              rom_tone_c;

  sound_sheet_rom u_rom (
    .id     (id_q),
    .step   (step_q),
    .tone_c (rom_tone_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pending_q    <= '0;
      step_q       <= '0;
      cnt_q        <= '0;
      id_q         <= '0;
      done_q       <= 1'b0;
      tone_key     <= REST;
      sound_enable <= 1'b0;
      busy         <= 1'b0;
      active_id    <= '0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      step_q       <= step_d;
      cnt_q        <= cnt_d;
      id_q         <= id_d;
      done_q       <= done_d;
      // Outputs trail the internal state by one clock.
      tone_key     <= (state_q == ST_PLAY) ? rom_tone_c : REST;
      sound_enable <= (state_q == ST_PLAY) && (rom_tone_c != REST) && !mute;
      busy         <= (state_q != ST_IDLE);
      active_id    <= id_q;
      done         <= done_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    done_d    = 1'b0;
    req_mask  = req;
    sel       = '0;
    higher    = 1'b0;
    last_step = STEP_W'(SHEET_LEN[id_q] - 4'd1);

    // Preemption only sees requests already latched before this cycle.
    for (int i = 0; i < N_REQ; i++) begin
      if (pending_q[i] && (ID_W'(i) > id_q)) higher = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (|pending_q) begin
          for (int i = 0; i < N_REQ; i++) begin
            if (pending_q[i]) sel = ID_W'(i);
          end
          id_d           = sel;
          pending_d[sel] = 1'b0;
          step_d         = '0;
          cnt_d          = '0;
          state_d        = ST_PLAY;
        end
      end
      ST_PLAY: begin
        req_mask[id_q] = 1'b0;
        if (start_of_frame) begin
          if (cnt_q == EIGHTH_LAST) begin
            cnt_d = '0;
            if (step_q == last_step) begin
              done_d  = 1'b1;
              state_d = ST_GAP;
            end else if (higher) begin
              state_d = ST_GAP;
            end else begin
              step_d = STEP_W'(step_q + 1'b1);
            end
          end else begin
            cnt_d = CNT_W'(cnt_q + 1'b1);
          end
        end
      end
      ST_GAP: begin
        if (start_of_frame) begin
          if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = CNT_W'(cnt_q + 1'b1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // New requests land after selection clears, so a same-cycle request survives.
    pending_d = pending_d | req_mask;
  end

endmodule
